conv_encoder_framed: RTL and testbench
======================================

Name: conv_encoder_framed

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder; sits directly upstream of the team's Viterbi decoder and produces the 2-bit parity pairs that decoder consumes.
- Generators: parities[1] = g 111 (u ^ s0 ^ s1), parities[0] = g 101 (u ^ s1).
- Accepts a framed serial bit stream over a valid/ready handshake and appends K-1 = 2 zero tail bits per frame. The trellis therefore returns to state 00 at every frame end, which is the decoder's required start state.

Parameters:
- TAIL_LEN, 2, number of zero flush bits appended after in_last; fixed at K-1, any other value is illegal.
- CNT_W, 16, width of the optional encoded-bit counter.

Ports:
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- in_bit  in  1  information bit
- in_valid  in  1  in_bit valid
- in_last  in  1  in_bit is the final information bit of the frame
- in_ready  out  1  encoder can accept in_bit this cycle
- parities  out  2  encoded pair {g111, g101}
- out_valid  out  1  parities valid
- out_last  out  1  pair is the final tail pair of the frame
- out_ready  in  1  downstream accepts parities this cycle
- bit_count  out  CNT_W  pairs emitted in current frame (only with ENC_STATUS_EN)

Behaviour:
- Reset (RST_N low, asynchronous, any time including mid-frame):
  - parities=00, out_valid=0, out_last=0.
  - shift register {s1,s0}=00, FSM=IDLE, bit_count=0.
  - Any partial frame is discarded.
- Shift register update on each encoded bit u: {s1,s0} <= {s0,u}. s0 is the previous bit, s1 the bit before it.
- Output slot: one register, slot_free = !out_valid || out_ready.
- in_ready = slot_free && FSM in {IDLE, DATA}. It is combinational on out_valid/out_ready and never depends on in_valid.
- Input accept at a rising edge when in_valid && in_ready:
  - parities <= {u^s0^s1, u^s1}, out_valid <= 1, out_last <= 0, shift register updates.
  - Latency: pair is visible on the cycle after acceptance.
  - Back-to-back acceptance gives throughput of 1 pair per cycle.
- FSM:
  - IDLE: accept -> DATA, or -> TAIL1 if in_last.
  - DATA: accept with in_last -> TAIL1; other accepts stay in DATA.
  - TAIL1: when slot_free, emit u=0 pair -> TAIL2.
  - TAIL2: when slot_free, emit u=0 pair with out_last=1, shift register becomes 00 -> IDLE.
  - in_ready=0 throughout TAIL1/TAIL2.
- Frame output length: exactly N+2 pairs for N information bits; a single-bit frame (in_last on the first bit) yields 3 pairs.
- Output hold: parities and out_last hold stable while out_valid && !out_ready. If out_ready and no new pair is produced, out_valid <= 0.
- in_valid may toggle freely; with in_valid low in DATA the FSM waits, state is held, and no pair is emitted.
- in_last while in IDLE/DATA is sampled only on accept.

Optional Feature:
- Macro: ENC_STATUS_EN.
- Defined:
  - bit_count port exists.
  - Increments by 1 on every pair loaded into the output register, including tail pairs.
  - Clears to 0 on the cycle the out_last pair is loaded, so it reads 0 in IDLE.
  - Saturates at all-ones.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Frame 1,0,1,1 (last on 4th), out_ready=1 -> parities 11,10,00,01,01,11 on consecutive cycles; out_last only on the 6th; shift register 00 after.
- Same frame with out_ready low for 3 cycles after the 2nd pair -> 10 held stable with out_valid=1, in_ready=0 during stall, no pair lost or duplicated, same 6-pair sequence.
- Single bit 1 with in_last -> 11,10,11; out_last on the 3rd; in_ready=0 for the two tail cycles, then 1.
- All-zero frame of 5 bits -> seven 00 pairs, out_last on the 7th; next frame starting with bit 1 yields 11, proving the state reset to 00.
- RST_N asserted asynchronously mid-frame after bits 1,1 -> out_valid=0 immediately. After release, frame 1 with last -> 11,10,11, with no residue from the aborted frame.
- ENC_STATUS_EN defined, 4-bit frame -> bit_count reads 1..5 on successive pair loads, 0 after the out_last pair; undefined build compiles without the port.

Source files
------------

// File: rtl/conv_encoder_framed.sv
// Framed rate-1/2 K=3 convolutional encoder (g 111, g 101) that
// flushes every frame with two zero tail bits so the trellis ends in 00.
//
// Ports:
//   CLK, RST_N           clock, async active-low reset
//   in_bit/in_valid/     framed information bit stream
//   in_last/in_ready
//   parities             {g111, g101} pair
//   out_valid/out_last/  output handshake, out_last on final tail pair
//   out_ready
//   bit_count            pairs emitted in frame (ENC_STATUS_EN only)
//
// Optional feature macro: ENC_STATUS_EN (adds bit_count and CNT_W).
module conv_encoder_framed #(
  parameter int TAIL_LEN = 2
`ifdef ENC_STATUS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [1:0]       parities,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready
`ifdef ENC_STATUS_EN
  , output logic [CNT_W-1:0] bit_count
`endif
);

  if (TAIL_LEN != 2) begin : g_bad_tail
    $error("TAIL_LEN must equal K-1 = 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL1,
    TAIL2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] sr;
  logic       slot_free;
  logic       load;
  logic       u;
  logic       last_pair;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free &&
                     (state == IDLE || state == DATA);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    u         = 1'b0;
    last_pair = 1'b0;
    unique case (state)
      IDLE, DATA: begin
        if (in_valid && in_ready) begin
          load      = 1'b1;
          u         = in_bit;
          state_nxt = in_last ? TAIL1 : DATA;
        end
      end
      TAIL1: begin
        if (slot_free) begin
          load      = 1'b1;
          state_nxt = TAIL2;
        end
      end
      TAIL2: begin
        if (slot_free) begin
          load      = 1'b1;
          last_pair = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // sr = {s1, s0}; two zero tail bits leave it at 00.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sr        <= 2'b00;
      parities  <= 2'b00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      parities  <= {u ^ sr[0] ^ sr[1], u ^ sr[1]};
      out_valid <= 1'b1;
      out_last  <= last_pair;
      sr        <= {sr[0], u};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ENC_STATUS_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_count <= '0;
    end else if (load) begin
      if (last_pair)
        bit_count <= '0;
      else if (bit_count != {CNT_W{1'b1}})
        bit_count <= bit_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_encoder_framed.sv
// Self-checking bench for conv_encoder_framed.
// Reference pairs come from a direct generator-polynomial convolution.
module tb_conv_encoder_framed;

  logic       CLK;
  logic       RST_N;
  logic       in_bit;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [1:0] parities;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
`ifdef ENC_STATUS_EN
  logic [15:0] bit_count;
`endif

  conv_encoder_framed dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .parities  (parities),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
`ifdef ENC_STATUS_EN
    , .bit_count (bit_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  bit         fb[$];
  logic [1:0] expq[$];
  logic [1:0] obs[$];
  bit         obs_last[$];
  int         obs_cnt[$];

  // Convolution: pair i uses b[i], b[i-1], b[i-2], zeros outside frame.
  task automatic build_exp();
    int n;
    bit u, a, c;
    n = fb.size();
    expq.delete();
    for (int i = 0; i < n + 2; i++) begin
      u = (i < n) ? fb[i] : 1'b0;
      a = (i >= 1 && i - 1 < n) ? fb[i-1] : 1'b0;
      c = (i >= 2 && i - 2 < n) ? fb[i-2] : 1'b0;
      expq.push_back({u ^ a ^ c, u ^ c});
    end
  endtask

  // Streams fb[] through the DUT and records every transferred pair.
  task automatic run_frame(input bit rv, input bit rr,
                           input int st_at, input int st_len,
                           output int herr, output bit tmo);
    int         idx;
    int         n;
    int         stc;
    bit         done;
    bit         pstall;
    logic [1:0] ppar;
    logic       plast;
    idx = 0; n = fb.size(); stc = 0;
    done = 0; pstall = 0; ppar = 2'b00; plast = 1'b0;
    herr = 0; tmo = 1;
    obs.delete(); obs_last.delete(); obs_cnt.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge CLK);
      if (obs.size() == st_at && stc < st_len) begin
        out_ready = 1'b0;
        stc++;
      end else begin
        out_ready = rr ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (idx < n) begin
        in_valid = rv ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_bit   = fb[idx];
        in_last  = (idx == n - 1);
      end else begin
        in_valid = 1'b0;
        in_bit   = 1'($urandom_range(0, 1));
        in_last  = 1'($urandom_range(0, 1));
      end
      #1;
      if (pstall && (!out_valid || parities !== ppar ||
                     out_last !== plast))
        herr++;
      if (out_valid && !out_ready && in_ready)
        herr++;
      if (out_valid && out_ready) begin
        obs.push_back(parities);
        obs_last.push_back(out_last);
`ifdef ENC_STATUS_EN
        obs_cnt.push_back(int'(bit_count));
`else
        obs_cnt.push_back(0);
`endif
        if (out_last) done = 1;
      end
      if (in_valid && in_ready) idx++;
      pstall = out_valid && !out_ready;
      ppar   = parities;
      plast  = out_last;
      if (done) begin
        tmo = 0;
        break;
      end
    end
    @(negedge CLK);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; in_bit = 1'b0; in_valid = 1'b0;
    in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    tests++;
    if (parities !== 2'b00 || out_valid !== 1'b0 ||
        out_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got %b/%b/%b want 00/0/0",
               parities, out_valid, out_last);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
`ifdef ENC_STATUS_EN
    tests++;
    if (bit_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_bit_count got %0d want 0", bit_count);
    end
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic_frame();
    int herr;
    bit tmo;
    logic [1:0] want [6];
    want = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    fb = '{1, 0, 1, 1};
    run_frame(0, 0, -1, 0, herr, tmo);
    tests++;
    if (tmo || obs.size() != 6) begin
      fails++;
      $display("FAIL basic_len got %0d tmo %0d want 6",
               obs.size(), tmo);
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (obs[i] !== want[i] || obs_last[i] !== (i == 5)) begin
          fails++;
          $display("FAIL basic_pair%0d got %b/%b want %b/%b",
                   i, obs[i], obs_last[i], want[i], i == 5);
        end
`ifdef ENC_STATUS_EN
        tests++;
        if (obs_cnt[i] != ((i == 5) ? 0 : i + 1)) begin
          fails++;
          $display("FAIL bit_count%0d got %0d want %0d",
                   i, obs_cnt[i], (i == 5) ? 0 : i + 1);
        end
`endif
      end
    end
  endtask

  task automatic test_stall();
    int herr;
    bit tmo;
    fb = '{1, 0, 1, 1};
    build_exp();
    run_frame(0, 0, 1, 3, herr, tmo);
    tests++;
    if (herr != 0) begin
      fails++;
      $display("FAIL stall_hold got %0d errs want 0", herr);
    end
    tests++;
    if (tmo || obs != expq) begin
      fails++;
      $display("FAIL stall_seq got %p want %p", obs, expq);
    end
  endtask

  task automatic test_single_bit();
    logic [1:0] want [3];
    want = '{2'b11, 2'b10, 2'b11};
    @(negedge CLK);
    in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_accept got %b want 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      in_valid = 1'b0; in_last = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b1 || parities !== want[i] ||
          out_last !== (i == 2) || in_ready !== (i == 2)) begin
        fails++;
        $display("FAIL single_pair%0d got %b/%b/%b rdy %b want %b",
                 i, out_valid, parities, out_last, in_ready, want[i]);
      end
    end
    @(negedge CLK);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_zero_frame();
    int herr;
    bit tmo;
    bit ok;
    fb = '{0, 0, 0, 0, 0};
    run_frame(0, 0, -1, 0, herr, tmo);
    ok = !tmo && obs.size() == 7;
    foreach (obs[i])
      if (obs[i] !== 2'b00 || obs_last[i] !== (i == 6)) ok = 0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL zero_frame got %p want seven 00", obs);
    end
    fb = '{1, 1};
    run_frame(0, 0, -1, 0, herr, tmo);
    tests++;
    if (tmo || obs.size() < 1 || obs[0] !== 2'b11) begin
      fails++;
      $display("FAIL zero_next_first got %p want 11 first", obs);
    end
  endtask

  task automatic test_async_reset();
    int herr;
    bit tmo;
    @(negedge CLK);
    in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    #2;
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre got %b want 1", out_valid);
    end
    RST_N = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || parities !== 2'b00) begin
      fails++;
      $display("FAIL abort_async got %b/%b want 0/00",
               out_valid, parities);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    fb = '{1};
    build_exp();
    run_frame(0, 0, -1, 0, herr, tmo);
    tests++;
    if (tmo || obs != expq) begin
      fails++;
      $display("FAIL abort_after got %p want %p", obs, expq);
    end
  endtask

  task automatic test_random();
    int herr;
    bit tmo;
    int n;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 20);
      fb.delete();
      for (int i = 0; i < n; i++)
        fb.push_back(1'($urandom_range(0, 1)));
      build_exp();
      run_frame(1, 1, -1, 0, herr, tmo);
      tests++;
      if (tmo || obs != expq) begin
        fails++;
        $display("FAIL rand%0d_seq n=%0d got %p want %p",
                 f, n, obs, expq);
      end
      tests++;
      if (herr != 0) begin
        fails++;
        $display("FAIL rand%0d_hold got %0d want 0", f, herr);
      end
      for (int i = 0; i < obs_last.size(); i++) begin
        tests++;
        if (obs_last[i] !== (i == n + 1)) begin
          fails++;
          $display("FAIL rand%0d_last%0d got %b want %b",
                   f, i, obs_last[i], i == n + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_single_bit();
    test_zero_frame();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
